// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter fed by a power-of-two FIFO; frames go out back-to-back
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic [DATA_BITS-1:0]          i_data,
  output logic                          o_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_tx,
  output logic                          o_active,
  output logic                          o_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [NW-1:0] FULL      = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [NW-1:0]        count;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 frame_end;
  logic [DATA_BITS-1:0] rd_word;
  logic                 load_par;

  assign o_ready   = (count != FULL);
  assign o_count   = count;
  assign push      = i_valid && o_ready;
  assign bit_end   = (cnt == BIT_LAST);
  assign frame_end = (state == S_STOP) && bit_end && (bit_idx == STOP_LAST);
  // The next word is taken either from idle or on the last stop cycle, so queued frames abut.
  assign pop       = (count != '0) && ((state == S_IDLE) || frame_end);
  assign rd_word   = mem[rd_ptr];
  assign load_par  = (PARITY == 1) ? ~^rd_word : ^rd_word;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      o_tx     <= 1'b1;
      o_active <= 1'b0;
      o_done   <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state != S_IDLE) begin
        cnt <= bit_end ? '0 : cnt + CW'(1);
      end
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (pop) begin
            shreg    <= rd_word;
            par_bit  <= load_par;
            o_tx     <= 1'b0;
            o_active <= 1'b1;
            state    <= S_START;
          end else begin
            o_tx     <= 1'b1;
            o_active <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            o_tx    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                o_tx  <= par_bit;
                state <= S_PAR;
              end else begin
                o_tx  <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + IW'(1);
              o_tx    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        S_PAR: begin
          if (bit_end) begin
            o_tx    <= 1'b1;
            bit_idx <= '0;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (bit_idx == STOP_LAST) begin
              o_done  <= 1'b1;
              bit_idx <= '0;
              if (pop) begin
                shreg   <= rd_word;
                par_bit <= load_par;
                o_tx    <= 1'b0;
                state   <= S_START;
              end else begin
                o_active <= 1'b0;
                state    <= S_IDLE;
              end
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
        default: begin
          o_tx     <= 1'b1;
          o_active <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
